ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 57 +++++
 rtl/ex_stage.sv | 98 +++++++++
 tb/tb_ex_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX operands and controls in, EX/MEM register and stall out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_stage_if;
    logic [1:0]  ula_in;
    logic        mux_ula_in;
    logic        mem_rd_in;
    logic        mem_wr_in;
    logic        reg_wr_in;
    logic        mux_reg_wr_in;
    logic [31:0] imm_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_in;
    logic [6:0]  funct7_in;
    logic [2:0]  funct3_in;
    logic [31:0] val_A_in;
    logic [31:0] val_B_in;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        wb_reg_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        enable;
    logic [31:0] alu_out;
    logic [31:0] store_data_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        zero_out;
    logic        mem_rd_out;
    logic        mem_wr_out;
    logic        reg_wr_out;
    logic        mux_reg_wr_out;
    logic        stall;

    modport master (
        output ula_in, mux_ula_in, mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in,
        output imm_in, rs1_in, rs2_in, rd_in, funct7_in, funct3_in, val_A_in, val_B_in,
        output id_rs1, id_rs2, wb_reg_wr, wb_rd, wb_data, enable,
        input  alu_out, store_data_out, rd_out, funct3_out, zero_out,
        input  mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out, stall
    );

    modport slave (
        input  ula_in, mux_ula_in, mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in,
        input  imm_in, rs1_in, rs2_in, rd_in, funct7_in, funct3_in, val_A_in, val_B_in,
        input  id_rs1, id_rs2, wb_reg_wr, wb_rd, wb_data, enable,
        output alu_out, store_data_out, rd_out, funct3_out, zero_out,
        output mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out, stall
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Brief    : Execute stage: operand forwarding, ALU, EX/MEM register, load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        unused_funct7;

    assign unused_funct7 = ^{bus.funct7_in[6], bus.funct7_in[4:0]};

    // The EX/MEM result is younger than MEM/WB, so it wins when both match.
    always_comb begin
        w_fwd_a = bus.val_A_in;
        if (bus.reg_wr_out && (bus.rd_out != 5'd0) && (bus.rd_out == bus.rs1_in))
            w_fwd_a = bus.alu_out;
        else if (bus.wb_reg_wr && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs1_in))
            w_fwd_a = bus.wb_data;
    end

    always_comb begin
        w_fwd_b = bus.val_B_in;
        if (bus.reg_wr_out && (bus.rd_out != 5'd0) && (bus.rd_out == bus.rs2_in))
            w_fwd_b = bus.alu_out;
        else if (bus.wb_reg_wr && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs2_in))
            w_fwd_b = bus.wb_data;
    end

    assign w_op_b  = bus.mux_ula_in ? bus.imm_in : w_fwd_b;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_result = 32'd0;
        case (bus.ula_in)
            2'b00: w_result = w_fwd_a + w_op_b;
            2'b01: w_result = w_fwd_a - w_op_b;
            2'b11: w_result = bus.imm_in;
            default: begin
                case (bus.funct3_in)
                    // Immediate forms never subtract, even if imm bit 30 is set.
                    3'b000: w_result = (bus.funct7_in[5] && !bus.mux_ula_in)
                                       ? (w_fwd_a - w_op_b) : (w_fwd_a + w_op_b);
                    3'b001: w_result = w_fwd_a << w_shamt;
                    3'b010: w_result = {31'd0, ($signed(w_fwd_a) < $signed(w_op_b))};
                    3'b011: w_result = {31'd0, (w_fwd_a < w_op_b)};
                    3'b100: w_result = w_fwd_a ^ w_op_b;
                    3'b101: w_result = bus.funct7_in[5]
                                       ? $unsigned($signed(w_fwd_a) >>> w_shamt)
                                       : (w_fwd_a >> w_shamt);
                    3'b110: w_result = w_fwd_a | w_op_b;
                    default: w_result = w_fwd_a & w_op_b;
                endcase
            end
        endcase
    end

    // Stall only flags the hazard; the instruction in EX still advances.
    assign bus.stall = bus.mem_rd_in && (bus.rd_in != 5'd0) &&
                       ((bus.rd_in == bus.id_rs1) || (bus.rd_in == bus.id_rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_out        <= 32'd0;
            bus.store_data_out <= 32'd0;
            bus.rd_out         <= 5'd0;
            bus.funct3_out     <= 3'd0;
            bus.zero_out       <= 1'b0;
            bus.mem_rd_out     <= 1'b0;
            bus.mem_wr_out     <= 1'b0;
            bus.reg_wr_out     <= 1'b0;
            bus.mux_reg_wr_out <= 1'b0;
        end else if (bus.enable) begin
            bus.alu_out        <= w_result;
            bus.store_data_out <= w_fwd_b;
            bus.rd_out         <= bus.rd_in;
            bus.funct3_out     <= bus.funct3_in;
            bus.zero_out       <= (w_result == 32'd0);
            bus.mem_rd_out     <= bus.mem_rd_in;
            bus.mem_wr_out     <= bus.mem_wr_in;
            bus.reg_wr_out     <= bus.reg_wr_in;
            bus.mux_reg_wr_out <= bus.mux_reg_wr_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Scoreboard bench for ex_stage: forwarding, ALU ops, hold, stall, reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;

    logic clk;
    logic rst;
    ex_stage_if bus ();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        zero;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] out_ctrl();
        return {bus.mem_rd_out, bus.mem_wr_out, bus.reg_wr_out, bus.mux_reg_wr_out};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".alu"},   bus.alu_out, 32'd0);
        check({tag, ".store"}, bus.store_data_out, 32'd0);
        check({tag, ".misc"},  {19'd0, bus.rd_out, bus.funct3_out, bus.zero_out, out_ctrl()}, 32'd0);
    endtask

    task automatic drive(input logic [1:0] ula, input logic mux, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
        bus.ula_in = ula;  bus.mux_ula_in = mux;  bus.imm_in = imm;
        bus.rs1_in = rs1;  bus.rs2_in = rs2;      bus.rd_in = rd;
        bus.funct7_in = f7; bus.funct3_in = f3;
        bus.val_A_in = a;  bus.val_B_in = b;
        {bus.mem_rd_in, bus.mem_wr_in, bus.reg_wr_in, bus.mux_reg_wr_in} = ctrl;
    endtask

    // Drive one instruction with capture enabled, then compare after the edge.
    task automatic issue(input string tag, input logic [1:0] ula, input logic mux,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                         input logic [31:0] e_alu, input logic [31:0] e_store);
        exp_t e;
        drive(ula, mux, imm, rs1, rs2, rd, f7, f3, a, b, ctrl);
        bus.enable = 1'b1;
        sb.push_back('{alu: e_alu, store: e_store, rd: rd, f3: f3,
                       zero: (e_alu == 32'd0), ctrl: ctrl});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".alu"},   bus.alu_out, e.alu);
            check({tag, ".store"}, bus.store_data_out, e.store);
            check({tag, ".rd"},    {27'd0, bus.rd_out}, {27'd0, e.rd});
            check({tag, ".f3"},    {29'd0, bus.funct3_out}, {29'd0, e.f3});
            check({tag, ".zero"},  {31'd0, bus.zero_out}, {31'd0, e.zero});
            check({tag, ".ctrl"},  {28'd0, out_ctrl()}, {28'd0, e.ctrl});
            last_exp = e;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;
        bus.wb_reg_wr = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        drive(2'b00, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 7'd0, 3'd0, 32'd0, 32'd0, 4'd0);
        #12;
        check_zero("reset_held");
        bus.enable = 1'b1;
        drive(2'b00, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 7'd0, 3'd0, 32'd5, 32'd6, 4'b0010);
        @(posedge clk); #1;
        check_zero("reset_ignores_enable");
        bus.enable = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_zero("after_release");

        // Back-to-back forwarding: ADD x5 = 7 + 3, then SUB x6 = x5 - x5 with stale operands.
        issue("add_x5", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd5, 7'h00, 3'b000, 32'd7, 32'd3, 4'b0010, 32'd10, 32'd3);
        issue("sub_fwd", 2'b10, 1'b0, 32'd0, 5'd5, 5'd5, 5'd6, 7'h20, 3'b000, 32'd0, 32'd0, 4'b0010, 32'd0, 32'd10);

        // EX/MEM beats MEM/WB on rs1=4.
        issue("mk_x4", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd4, 7'h00, 3'b000, 32'd5, 32'd6, 4'b0010, 32'd11, 32'd6);
        bus.wb_reg_wr = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'd22;
        issue("prio", 2'b10, 1'b0, 32'd0, 5'd4, 5'd0, 5'd7, 7'h00, 3'b000, 32'd100, 32'd1, 4'b0010, 32'd12, 32'd1);
        // MEM/WB alone forwards to rs2 once EX/MEM no longer matches.
        issue("wb_fwd", 2'b10, 1'b0, 32'd0, 5'd1, 5'd4, 5'd9, 7'h00, 3'b000, 32'd3, 32'd0, 4'b0010, 32'd25, 32'd22);

        // x0 is never forwarded from either stage.
        issue("mk_x0", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd0, 7'h00, 3'b000, 32'd9, 32'd0, 4'b0010, 32'd9, 32'd0);
        bus.wb_rd = 5'd0;
        issue("x0_nofwd", 2'b10, 1'b0, 32'd0, 5'd0, 5'd0, 5'd11, 7'h00, 3'b000, 32'd40, 32'd2, 4'b0000, 32'd42, 32'd2);
        bus.wb_reg_wr = 1'b0;

        // Shifts, compares and remaining ALU functions (no forwarding: reg_wr off).
        issue("sra_imm", 2'b10, 1'b1, 32'd4, 5'd1, 5'd2, 5'd10, 7'h20, 3'b101, 32'h80000000, 32'd0, 4'b0000, 32'hF8000000, 32'd0);
        issue("srl_imm", 2'b10, 1'b1, 32'd4, 5'd1, 5'd2, 5'd10, 7'h00, 3'b101, 32'h80000000, 32'd0, 4'b0000, 32'h08000000, 32'd0);
        issue("srl_reg", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b101, 32'h80000000, 32'd36, 4'b0000, 32'h08000000, 32'd36);
        issue("slt", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd1, 32'd1);
        issue("sltu", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd0, 32'd1);
        issue("sll", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b001, 32'd1, 32'd33, 4'b0000, 32'd2, 32'd33);
        issue("xor", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b100, 32'hF0F0, 32'h0FF0, 4'b0000, 32'hFF00, 32'h0FF0);
        issue("or", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b110, 32'hF0F0, 32'h0FF0, 4'b0000, 32'hFFF0, 32'h0FF0);
        issue("and", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 7'h00, 3'b111, 32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, 32'h0FF0);
        issue("addi_f7", 2'b10, 1'b1, 32'd4, 5'd1, 5'd2, 5'd10, 7'h20, 3'b000, 32'd10, 32'd0, 4'b0000, 32'd14, 32'd0);
        issue("ld_add", 2'b00, 1'b1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd12, 7'h00, 3'b010, 32'd100, 32'd7, 4'b1011, 32'd96, 32'd7);
        issue("br_sub", 2'b01, 1'b0, 32'd0, 5'd1, 5'd2, 5'd0, 7'h00, 3'b000, 32'd5, 32'd7, 4'b0000, 32'hFFFFFFFE, 32'd7);
        issue("st_wrap", 2'b00, 1'b0, 32'd0, 5'd1, 5'd2, 5'd0, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1, 4'b0100, 32'd0, 32'd1);
        issue("lui", 2'b11, 1'b1, 32'h12345000, 5'd1, 5'd2, 5'd13, 7'h00, 3'b000, 32'd1, 32'd2, 4'b0011, 32'h12345000, 32'd2);

        // Load-use stall is purely combinational.
        drive(2'b00, 1'b1, 32'd0, 5'd1, 5'd2, 5'd8, 7'h00, 3'b010, 32'd0, 32'd0, 4'b1011);
        bus.enable = 1'b0;
        bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd8; #1;
        check("stall_rs2", {31'd0, bus.stall}, 32'd1);
        bus.id_rs1 = 5'd8; bus.id_rs2 = 5'd3; #1;
        check("stall_rs1", {31'd0, bus.stall}, 32'd1);
        bus.id_rs1 = 5'd9; bus.id_rs2 = 5'd9; #1;
        check("stall_nomatch", {31'd0, bus.stall}, 32'd0);
        bus.mem_rd_in = 1'b0; bus.id_rs2 = 5'd8; #1;
        check("stall_not_load", {31'd0, bus.stall}, 32'd0);
        bus.mem_rd_in = 1'b1; bus.rd_in = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; #1;
        check("stall_x0", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;

        // Hold: three disabled edges with changing inputs leave outputs alone.
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1'b0, $urandom, 5'd1, 5'd2, 5'($urandom_range(1, 31)), 7'h00,
                  3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            bus.enable = 1'b0;
            @(posedge clk); #1;
            check("hold.alu", bus.alu_out, last_exp.alu);
            check("hold.misc", {19'd0, bus.rd_out, bus.funct3_out, bus.zero_out, out_ctrl()},
                  {19'd0, last_exp.rd, last_exp.f3, last_exp.zero, last_exp.ctrl});
        end
        issue("after_hold", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd14, 7'h00, 3'b000, 32'd20, 32'd22, 4'b0011, 32'd42, 32'd22);

        // Reset mid-operation drops the in-flight instruction.
        drive(2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd15, 7'h00, 3'b000, 32'd1, 32'd2, 4'b0010);
        bus.enable = 1'b1;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk); #1;
        check_zero("reset_edge");
        bus.enable = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("post_reset_idle");
        issue("post_reset", 2'b10, 1'b0, 32'd0, 5'd1, 5'd2, 5'd16, 7'h00, 3'b000, 32'd30, 32'd3, 4'b0010, 32'd33, 32'd3);

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
